pipeline_hazard_ctrl: RTL

Central stall/flush controller for the 5-stage pipeline. It drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB latches and the PC enable. It detects load-use hazards, taken branches and jumps, instruction-fetch misses and data-memory waits, and sticky halt. It also keeps saturating stall and flush performance counters.

---
 rtl/cpu_types_pkg.sv | 43 ++++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 32 +++
 rtl/pipeline_hazard_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register specifier width, NOP encoding, hazard controller state and control bundle.
package cpu_types_pkg;

    localparam int unsigned REGW_DEF  = 5;
    localparam int unsigned CNTW_DEF  = 32;
    localparam int unsigned WORDW     = 32;

    typedef logic [REGW_DEF-1:0] regbits_t;
    typedef logic [WORDW-1:0]    word_t;

    // sll $0,$0,0: what a flushed latch presents downstream
    localparam word_t NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } hazard_state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
        logic halt;
    } hazard_ctrl_t;

    function automatic hazard_ctrl_t ctrl_advance_all();
        hazard_ctrl_t c;
        c          = '0;
        c.pc_en    = 1'b1;
        c.ifid_en  = 1'b1;
        c.idex_en  = 1'b1;
        c.exmem_en = 1'b1;
        c.memwb_en = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
module sat_counter #(
    parameter int unsigned CNTW = 32
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            inc,
    output logic [CNTW-1:0] count
);

    logic [CNTW-1:0] count_q;
    logic [CNTW-1:0] count_d;

    // Hold at all-ones instead of wrapping
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + CNTW'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: latch enables, flushes, halt and perf counters.
module pipeline_hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int unsigned REGW = REGW_DEF,
    parameter int unsigned CNTW = CNTW_DEF
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            ihit,
    input  logic            dhit,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic            ex_dREN,
    input  logic [REGW-1:0] ex_rt,
    input  logic            ex_redirect,
    input  logic            mem_dREN,
    input  logic            mem_dWEN,
    input  logic            wb_halt,
    output logic            pc_en,
    output logic            ifid_en,
    output logic            idex_en,
    output logic            exmem_en,
    output logic            memwb_en,
    output logic            ifid_flush,
    output logic            idex_flush,
    output logic            exmem_flush,
    output logic            halt_out,
    output logic [CNTW-1:0] stall_cnt,
    output logic [CNTW-1:0] flush_cnt
);

    hazard_state_t state_q;
    hazard_state_t state_d;
    hazard_ctrl_t  ctrl;
    logic          mem_req;
    logic          mem_stall;
    logic          load_use;
    logic          halt_act;
    logic          redirect_fire;
    logic          stall_inc;

    always_comb begin
        mem_req   = mem_dREN | mem_dWEN;
        mem_stall = mem_req & ~dhit;
        load_use  = ex_dREN & (ex_rt != '0) & ((ex_rt == id_rs) | (ex_rt == id_rt));
        // A halt reaching WB stops the pipe in the same cycle it is seen
        halt_act  = (state_q == HALT) | wb_halt;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (wb_halt) begin
                    state_d = HALT;
                end else if (mem_stall) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (wb_halt) begin
                    state_d = HALT;
                end else if (!mem_stall) begin
                    state_d = RUN;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
    end

    // Priority: halt, memory freeze, redirect, load-use bubble, fetch miss, advance
    always_comb begin
        ctrl          = '0;
        redirect_fire = 1'b0;
        if (!nRST) begin
            ctrl = '0;
        end else if (halt_act) begin
            ctrl.halt = 1'b1;
        end else if (mem_stall) begin
            ctrl = '0;
        end else if (ex_redirect) begin
            ctrl            = ctrl_advance_all();
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_flush = 1'b1;
            redirect_fire   = 1'b1;
        end else if (load_use) begin
            ctrl.idex_en    = 1'b1;
            ctrl.idex_flush = 1'b1;
            ctrl.exmem_en   = 1'b1;
            ctrl.memwb_en   = 1'b1;
        end else if (!ihit) begin
            ctrl            = ctrl_advance_all();
            ctrl.pc_en      = 1'b0;
            ctrl.ifid_flush = 1'b1;
        end else begin
            ctrl = ctrl_advance_all();
        end
    end

    always_comb begin
        pc_en       = ctrl.pc_en;
        ifid_en     = ctrl.ifid_en;
        idex_en     = ctrl.idex_en;
        exmem_en    = ctrl.exmem_en;
        memwb_en    = ctrl.memwb_en;
        ifid_flush  = ctrl.ifid_flush;
        idex_flush  = ctrl.idex_flush;
        exmem_flush = ctrl.exmem_flush;
        halt_out    = ctrl.halt;
        stall_inc   = ~halt_act & ~(ctrl.pc_en & ctrl.ifid_en & ctrl.idex_en
                                    & ctrl.exmem_en & ctrl.memwb_en);
    end

    sat_counter #(.CNTW(CNTW)) u_stall_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.CNTW(CNTW)) u_flush_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (redirect_fire),
        .count (flush_cnt)
    );

endmodule
